wb_arb_scheduler: RTL and testbench

//  Grant scheduler for a shared pipelined Wishbone slave port with NUM_PORTS masters.

---
 rtl/wb_arb_scheduler.sv | 176 +++++++++++++++++
 tb/tb_wb_arb_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_arb_scheduler.sv
// Grant scheduler for a shared pipelined Wishbone slave: round-robin with starvation promotion,
// ownership held until the owner drops cyc and every outstanding ack/err has drained.
module wb_arb_scheduler #(
  parameter int unsigned NUM_PORTS         = 4,
  parameter int unsigned OUTST_W           = 4,
  parameter int unsigned STARVE_LIMIT      = 64,
  parameter bit          DEFAULT_TO_PORT_0 = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_stall_i,
  input  logic                         wbs_ack_i,
  input  logic                         wbs_err_i,
  output logic [NUM_PORTS-1:0]         grant_o,
  output logic                         grant_vld_o,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx_o,
  output logic [NUM_PORTS-1:0]         starved_o,
  output logic                         ovf_err_o
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPark  = 2'd1;
  localparam logic [1:0] StOwn   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [1:0]           StReset    = DEFAULT_TO_PORT_0 ? StPark : StIdle;
  localparam logic [NUM_PORTS-1:0] GrantReset = NUM_PORTS'(DEFAULT_TO_PORT_0);

  logic [1:0]                      state_q, state_d;
  logic [NUM_PORTS-1:0]            grant_q, grant_d;
  logic [IdxW-1:0]                 owner_q, owner_d;
  logic [IdxW-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [OUTST_W-1:0]              outst_q, outst_d;
  logic                            ovf_q, ovf_d;
  logic [NUM_PORTS-1:0][CntW-1:0]  starve_q, starve_d;
  logic [NUM_PORTS-1:0]            starved;

  logic            inc, dec, drained, rearb;
  logic            win_vld;
  logic [IdxW-1:0] win_idx;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NUM_PORTS;
    return IdxW'(s);
  endfunction

  // Outstanding transaction counter; simultaneous issue and completion cancel out.
  assign inc = wbs_stb_i & ~wbs_stall_i;
  assign dec = wbs_ack_i | wbs_err_i;

  always_comb begin
    outst_d = outst_q;
    ovf_d   = ovf_q;
    if (inc && !dec) begin
      if (outst_q == '1) ovf_d = 1'b1;
      else               outst_d = outst_q + 1'b1;
    end else if (dec && !inc) begin
      if (outst_q == '0) ovf_d = 1'b1;
      else               outst_d = outst_q - 1'b1;
    end
  end

  // The last ack may retire in the same cycle the grant moves on: it is routed by the old grant.
  assign drained = (outst_d == '0);

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      starved[p] = (starve_q[p] == CntW'(STARVE_LIMIT));
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_vld && starved[i] && req_i[i]) begin
        win_vld = 1'b1;
        win_idx = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_vld && req_i[rr_idx(rr_ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rearb    = 1'b0;
    unique case (state_q)
      StIdle: rearb = 1'b1;
      StPark: begin
        if (req_i[0]) begin
          // Parked grant is already on port 0, so it takes ownership without a bubble.
          state_d  = StOwn;
          rr_ptr_d = rr_idx('0, 1);
        end else if (win_vld && drained) begin
          rearb = 1'b1;
        end
      end
      StOwn: begin
        if (!req_i[owner_q]) begin
          if (drained) rearb = 1'b1;
          else         state_d = StDrain;
        end
      end
      StDrain: begin
        if (drained) rearb = 1'b1;
      end
      default: state_d = StReset;
    endcase

    if (rearb) begin
      if (win_vld) begin
        state_d  = StOwn;
        grant_d  = NUM_PORTS'(1) << win_idx;
        owner_d  = win_idx;
        rr_ptr_d = rr_idx(win_idx, 1);
      end else if (DEFAULT_TO_PORT_0) begin
        state_d = StPark;
        grant_d = NUM_PORTS'(1);
        owner_d = '0;
      end else begin
        state_d = StIdle;
        grant_d = '0;
        owner_d = '0;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!req_i[p] || grant_q[p] || grant_d[p]) starve_d[p] = '0;
      else if (starved[p])                      starve_d[p] = starve_q[p];
      else                                      starve_d[p] = starve_q[p] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StReset;
      grant_q  <= GrantReset;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      outst_q  <= '0;
      ovf_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      outst_q  <= outst_d;
      ovf_q    <= ovf_d;
      starve_q <= starve_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_vld_o = |grant_q;
  assign grant_idx_o = owner_q;
  assign starved_o   = starved;
  assign ovf_err_o   = ovf_q;

endmodule

// File: tb/tb_wb_arb_scheduler.sv
// Directed bench for wb_arb_scheduler: three instances (default, short starvation limit, parked
// on port 0) share one stimulus; expected grants go through a queue and are checked per cycle.
module tb_wb_arb_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req;
  logic       stb, stall, ack, err;

  logic [3:0] g_a, g_b, g_c, st_a, st_b, st_c;
  logic       v_a, v_b, v_c, o_a, o_b, o_c;
  logic [1:0] i_a, i_b, i_c;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] exp_q[$];

  wb_arb_scheduler u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wbs_stb_i(stb), .wbs_stall_i(stall),
    .wbs_ack_i(ack), .wbs_err_i(err), .grant_o(g_a), .grant_vld_o(v_a), .grant_idx_o(i_a),
    .starved_o(st_a), .ovf_err_o(o_a)
  );

  wb_arb_scheduler #(.STARVE_LIMIT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wbs_stb_i(stb), .wbs_stall_i(stall),
    .wbs_ack_i(ack), .wbs_err_i(err), .grant_o(g_b), .grant_vld_o(v_b), .grant_idx_o(i_b),
    .starved_o(st_b), .ovf_err_o(o_b)
  );

  wb_arb_scheduler #(.DEFAULT_TO_PORT_0(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wbs_stb_i(stb), .wbs_stall_i(stall),
    .wbs_ack_i(ack), .wbs_err_i(err), .grant_o(g_c), .grant_vld_o(v_c), .grant_idx_o(i_c),
    .starved_o(st_c), .ovf_err_o(o_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the expected grant after the edge is queued, then popped and compared.
  task automatic step(input int inst, input logic [3:0] r, input logic s, input logic a,
                      input logic [3:0] eg, input string tag);
    logic [3:0] obs;
    req = r;
    stb = s;
    ack = a;
    exp_q.push_back(eg);
    @(posedge clk);
    #1;
    obs = (inst == 0) ? g_a : (inst == 1) ? g_b : g_c;
    check(tag, {28'd0, obs}, {28'd0, exp_q.pop_front()});
  endtask

  task automatic do_reset();
    req   = '0;
    stb   = 1'b0;
    stall = 1'b0;
    ack   = 1'b0;
    err   = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_grant_a", {28'd0, g_a}, 32'h0);
    check("rst_vld_a", {31'd0, v_a}, 32'h0);
    check("rst_idx_a", {30'd0, i_a}, 32'h0);
    check("rst_starved_a", {28'd0, st_a}, 32'h0);
    check("rst_ovf_a", {31'd0, o_a}, 32'h0);
    check("rst_grant_c", {28'd0, g_c}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] cur, nxt;

    // T1: single master, three transfers, release.
    do_reset();
    step(0, 4'b0001, 1'b0, 1'b0, 4'b0001, "t1_grant");
    check("t1_vld", {31'd0, v_a}, 32'h1);
    check("t1_idx", {30'd0, i_a}, 32'h0);
    step(0, 4'b0001, 1'b1, 1'b0, 4'b0001, "t1_stb1");
    step(0, 4'b0001, 1'b1, 1'b1, 4'b0001, "t1_stb2");
    step(0, 4'b0001, 1'b1, 1'b1, 4'b0001, "t1_stb3");
    step(0, 4'b0001, 1'b0, 1'b1, 4'b0001, "t1_ack3");
    step(0, 4'b0000, 1'b0, 1'b0, 4'b0000, "t1_release");
    check("t1_vld_off", {31'd0, v_a}, 32'h0);

    // T2: all masters request; each owner drops cyc for one cycle after one transfer.
    do_reset();
    step(0, 4'b1111, 1'b0, 1'b0, 4'b0001, "t2_first");
    for (int k = 0; k < 4; k++) begin
      cur = 4'b0001 << k;
      nxt = 4'b0001 << ((k + 1) % 4);
      step(0, 4'b1111, 1'b1, 1'b0, cur, "t2_hold");
      step(0, 4'b1111, 1'b0, 1'b1, cur, "t2_ack");
      step(0, 4'b1111 & ~cur, 1'b0, 1'b0, nxt, "t2_handoff");
    end

    // T3: port 1 drops cyc with two transfers outstanding.
    do_reset();
    step(0, 4'b0010, 1'b0, 1'b0, 4'b0010, "t3_grant");
    check("t3_idx1", {30'd0, i_a}, 32'h1);
    step(0, 4'b0110, 1'b1, 1'b0, 4'b0010, "t3_stb1");
    step(0, 4'b0110, 1'b1, 1'b0, 4'b0010, "t3_stb2");
    step(0, 4'b0100, 1'b0, 1'b0, 4'b0010, "t3_drain");
    step(0, 4'b0100, 1'b0, 1'b1, 4'b0010, "t3_ack1");
    step(0, 4'b0100, 1'b0, 1'b1, 4'b0100, "t3_ack2");
    check("t3_idx2", {30'd0, i_a}, 32'h2);

    // T4: starvation limit 4; ports 2/3 starve behind port 0, port 1 joins late.
    do_reset();
    step(1, 4'b0001, 1'b0, 1'b0, 4'b0001, "t4_grant");
    for (int k = 0; k < 6; k++) step(1, 4'b1101, 1'b0, 1'b0, 4'b0001, "t4_hold");
    check("t4_starved", {28'd0, st_b}, 32'hC);
    for (int k = 0; k < 2; k++) step(1, 4'b1111, 1'b0, 1'b0, 4'b0001, "t4_hold_p1");
    check("t4_starved_p1", {28'd0, st_b}, 32'hC);
    step(1, 4'b1110, 1'b0, 1'b0, 4'b0100, "t4_promote");
    check("t4_starved_after", {28'd0, st_b}, 32'h8);

    // T5: parked on port 0.
    do_reset();
    check("t5_park_vld", {31'd0, v_c}, 32'h1);
    check("t5_park_idx", {30'd0, i_c}, 32'h0);
    step(2, 4'b0000, 1'b0, 1'b0, 4'b0001, "t5_park");
    step(2, 4'b0100, 1'b0, 1'b0, 4'b0100, "t5_other");
    step(2, 4'b0000, 1'b0, 1'b0, 4'b0001, "t5_repark");
    step(2, 4'b0001, 1'b0, 1'b0, 4'b0001, "t5_p0_own");
    step(2, 4'b0001, 1'b1, 1'b0, 4'b0001, "t5_p0_stb");
    step(2, 4'b0001, 1'b0, 1'b1, 4'b0001, "t5_p0_ack");
    step(2, 4'b0100, 1'b0, 1'b0, 4'b0100, "t5_handoff");

    // T6: counter underflow/overflow, sticky error, async reset mid-ownership.
    do_reset();
    step(0, 4'b0000, 1'b0, 1'b1, 4'b0000, "t6_underflow");
    check("t6_ovf_set", {31'd0, o_a}, 32'h1);
    for (int k = 0; k < 3; k++) step(0, 4'b0000, 1'b0, 1'b0, 4'b0000, "t6_idle");
    check("t6_ovf_sticky", {31'd0, o_a}, 32'h1);
    do_reset();
    for (int k = 0; k < 15; k++) step(0, 4'b0000, 1'b1, 1'b0, 4'b0000, "t6_fill");
    check("t6_ovf_full", {31'd0, o_a}, 32'h0);
    step(0, 4'b0000, 1'b1, 1'b0, 4'b0000, "t6_sat");
    check("t6_ovf_sat", {31'd0, o_a}, 32'h1);
    step(0, 4'b0010, 1'b0, 1'b0, 4'b0010, "t6_own");
    step(0, 4'b0010, 1'b1, 1'b0, 4'b0010, "t6_own_stb");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_grant", {28'd0, g_a}, 32'h0);
    check("t6_async_vld", {31'd0, v_a}, 32'h0);
    check("t6_async_idx", {30'd0, i_a}, 32'h0);
    check("t6_async_ovf", {31'd0, o_a}, 32'h0);
    req = 4'b0000;
    stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(0, 4'b0100, 1'b0, 1'b0, 4'b0100, "t6_regrant");
    step(0, 4'b0000, 1'b0, 1'b0, 4'b0000, "t6_discard");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
